board_input_conditioner: RTL and testbench

Parametrised board-input front end for the d16 system top. It produces the system reset, conditions raw asynchronous board inputs (keys, switches) into clean levels with edge pulses, and generates a free-running uptime counter plus a periodic tick. It generalises the fixed 3-stage reset shift and bare counter at the top level into configurable synchroniser depth, reset hold time, channel count, debounce and prescale. It sits directly behind the board pins and feeds `core` and the other peripherals.

---
 rtl/board_input_conditioner.sv | 171 +++++++++++++++++
 tb/tb_board_input_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_conditioner.sv
// board_input_conditioner
//
// Board-facing front end for the d16 system top. It produces the system
// reset, turns raw asynchronous board inputs (keys, switches) into clean
// debounced levels with one-cycle edge pulses, and runs a free-running
// uptime counter plus a periodic tick.
//
// Ports
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low board reset
//   raw_in     in   N_IN   asynchronous board inputs
//   sys_rst_n  out  1      system reset: asserts asynchronously, releases
//                          synchronously SYNC_STAGES+RST_HOLD edges after rst_n
//   level      out  N_IN   debounced input levels
//   rise       out  N_IN   one-cycle pulse when a level bit goes 0->1
//   fall       out  N_IN   one-cycle pulse when a level bit goes 1->0
//   tick       out  1      one-cycle pulse every TICK_DIV cycles
//   uptime     out  CNT_W  cycles since sys_rst_n released (wraps silently)
module board_input_conditioner #(
   parameter int              N_IN            = 4,
   parameter int              SYNC_STAGES     = 3,
   parameter int              RST_HOLD        = 256,
   parameter int              DEBOUNCE_CYCLES = 50000,
   parameter int              DB_W            = 16,
   parameter int              TICK_DIV        = 50000000,
   parameter int              CNT_W           = 24,
   parameter logic [N_IN-1:0] INIT_LEVEL      = {N_IN{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  raw_in,
   output logic             sys_rst_n,
   output logic [N_IN-1:0]  level,
   output logic [N_IN-1:0]  rise,
   output logic [N_IN-1:0]  fall,
   output logic             tick,
   output logic [CNT_W-1:0] uptime
);

   localparam int              PW       = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
   localparam logic [PW-1:0]   P_LAST   = PW'(TICK_DIV - 1);
   // tick is registered, so it is loaded one count early to line up with
   // the cycle in which pcnt reads TICK_DIV-1.
   localparam logic [PW-1:0]   P_PRE    = PW'(TICK_DIV - 2);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Reset generator: release synchroniser followed by the hold counter
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rst_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_chain <= '0;
      end else begin
         rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   generate
      if (RST_HOLD == 0) begin : g_no_hold
         // With no hold time the last synchroniser flop is the reset register.
         assign sys_rst_n = rst_chain[SYNC_STAGES-1];
      end else begin : g_hold
         localparam int            HOLD_W    = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);
         localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

         logic [HOLD_W-1:0] hold_cnt;
         logic              rst_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hold_cnt <= '0;
               rst_q    <= 1'b0;
            end else if (rst_chain[SYNC_STAGES-1] && !rst_q) begin
               if (hold_cnt == HOLD_LAST) begin
                  rst_q <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
         end

         assign sys_rst_n = rst_q;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Input synchronisers (run through the hold period, not gated by sys_rst_n)
   // ---------------------------------------------------------------------
   logic [N_IN-1:0] in_sync [SYNC_STAGES];
   logic [N_IN-1:0] synced;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            in_sync[s] <= INIT_LEVEL;
         end
      end else begin
         in_sync[0] <= raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            in_sync[s] <= in_sync[s-1];
         end
      end
   end

   assign synced = in_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Per-channel debounce with registered edge pulses
   // ---------------------------------------------------------------------
   logic [DB_W-1:0] db_cnt [N_IN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < N_IN; ch++) begin
            db_cnt[ch] <= '0;
            level[ch]  <= INIT_LEVEL[ch];
            rise[ch]   <= 1'b0;
            fall[ch]   <= 1'b0;
         end
      end else if (!sys_rst_n) begin
         for (int ch = 0; ch < N_IN; ch++) begin
            db_cnt[ch] <= '0;
            level[ch]  <= INIT_LEVEL[ch];
            rise[ch]   <= 1'b0;
            fall[ch]   <= 1'b0;
         end
      end else begin
         for (int ch = 0; ch < N_IN; ch++) begin
            rise[ch] <= 1'b0;
            fall[ch] <= 1'b0;
            if (synced[ch] != level[ch]) begin
               if (db_cnt[ch] == DB_LAST) begin
                  level[ch]  <= synced[ch];
                  db_cnt[ch] <= '0;
                  rise[ch]   <= synced[ch];
                  fall[ch]   <= ~synced[ch];
               end else begin
                  db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
               end
            end else begin
               // Input agrees with level again: any partial count was a glitch.
               db_cnt[ch] <= '0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Prescaler, tick and uptime
   // ---------------------------------------------------------------------
   logic [PW-1:0] pcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt   <= '0;
         tick   <= 1'b0;
         uptime <= '0;
      end else if (!sys_rst_n) begin
         pcnt   <= '0;
         tick   <= 1'b0;
         uptime <= '0;
      end else begin
         pcnt   <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
         tick   <= (pcnt == P_PRE);
         uptime <= uptime + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Testbench for board_input_conditioner with a small configuration
// (2 channels, 2 sync stages, hold 3, debounce 4, tick every 5, 8-bit uptime).
// Expected edge pulses are queued when raw_in is driven and compared by a
// monitor when the DUT shows pulses (or when a queued pulse is due).
module tb_board_input_conditioner;

   logic       clk;
   logic       rst_n;
   logic [1:0] raw_in;
   logic       sys_rst_n;
   logic [1:0] level;
   logic [1:0] rise;
   logic [1:0] fall;
   logic       tick;
   logic [7:0] uptime;

   board_input_conditioner #(
      .N_IN            (2),
      .SYNC_STAGES     (2),
      .RST_HOLD        (3),
      .DEBOUNCE_CYCLES (4),
      .DB_W            (3),
      .TICK_DIV        (5),
      .CNT_W           (8),
      .INIT_LEVEL      (2'b00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_in    (raw_in),
      .sys_rst_n (sys_rst_n),
      .level     (level),
      .rise      (rise),
      .fall      (fall),
      .tick      (tick),
      .uptime    (uptime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] r;
      logic [1:0] f;
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  n_chk  = 0;
   int  n_pass = 0;
   bit  mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse scoreboard: fires on any observed pulse or when a queued one is due.
   always @(negedge clk) begin
      ev_t e;
      if (mon_en && (((rise | fall) != 2'b00) || (exp_q.size() > 0 && exp_q[0].cyc <= cyc))) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL pulse_unexpected cyc=%0d rise=%b fall=%b required no pulse", cyc, rise, fall);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.r !== rise || e.f !== fall)
               $display("FAIL pulse cyc=%0d rise=%b fall=%b required cyc=%0d rise=%b fall=%b",
                        cyc, rise, fall, e.cyc, e.r, e.f);
            else
               n_pass++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int dly, input logic [1:0] r, input logic [1:0] f);
      ev_t e;
      e.cyc = cyc + dly;
      e.r   = r;
      e.f   = f;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      logic [15:0] obs;
      rst_n  = 1'b0;
      raw_in = 2'b00;
      step(10);
      obs = {sys_rst_n, level, rise, fall, tick, uptime};
      n_chk++;
      if (obs !== 16'h0000) $display("FAIL reset_state got=%h required=%h", obs, 16'h0000);
      else n_pass++;
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         obs = {sys_rst_n, level, rise, fall, tick, uptime};
         n_chk++;
         if (obs !== ((k == 5) ? 16'h8000 : 16'h0000))
            $display("FAIL reset_release edge=%0d got=%h required=%h", k, obs,
                     (k == 5) ? 16'h8000 : 16'h0000);
         else n_pass++;
      end
   endtask

   // Entered in the first cycle with sys_rst_n=1 (cycle 1).
   task automatic test_tick_uptime();
      logic [7:0] exp_up;
      logic       exp_tk;
      mon_en = 1'b1;
      for (int k = 1; k <= 260; k++) begin
         if (k > 1) step(1);
         exp_up = 8'((k - 1) % 256);
         exp_tk = ((k % 5) == 0);
         n_chk++;
         if (tick !== exp_tk || uptime !== exp_up)
            $display("FAIL tick_uptime cycle=%0d tick=%b uptime=%0d required tick=%b uptime=%0d",
                     k, tick, uptime, exp_tk, exp_up);
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      raw_in[0] = 1'b1;
      push_ev(6, 2'b01, 2'b00);
      step(5);
      n_chk++;
      if (level !== 2'b00) $display("FAIL press_early level=%b required=%b", level, 2'b00);
      else n_pass++;
      step(1);
      n_chk++;
      if (level !== 2'b01) $display("FAIL press_level level=%b required=%b", level, 2'b01);
      else n_pass++;
      step(3);
      raw_in[0] = 1'b0;
      push_ev(6, 2'b00, 2'b01);
      step(5);
      n_chk++;
      if (level !== 2'b01) $display("FAIL release_early level=%b required=%b", level, 2'b01);
      else n_pass++;
      step(1);
      n_chk++;
      if (level !== 2'b00) $display("FAIL release_level level=%b required=%b", level, 2'b00);
      else n_pass++;
      step(3);
   endtask

   task automatic test_glitch();
      raw_in[1] = 1'b1;
      step(3);
      raw_in[1] = 1'b0;
      step(8);
      n_chk++;
      if (level !== 2'b00) $display("FAIL glitch3_level level=%b required=%b", level, 2'b00);
      else n_pass++;
      // Four cycles high is just long enough to be accepted.
      raw_in[1] = 1'b1;
      push_ev(6, 2'b10, 2'b00);
      push_ev(10, 2'b00, 2'b10);
      step(4);
      raw_in[1] = 1'b0;
      step(2);
      n_chk++;
      if (level !== 2'b10) $display("FAIL glitch4_rise level=%b required=%b", level, 2'b10);
      else n_pass++;
      step(3);
      n_chk++;
      if (level !== 2'b10) $display("FAIL glitch4_hold level=%b required=%b", level, 2'b10);
      else n_pass++;
      step(1);
      n_chk++;
      if (level !== 2'b00) $display("FAIL glitch4_fall level=%b required=%b", level, 2'b00);
      else n_pass++;
      step(4);
   endtask

   task automatic test_mid_reset();
      logic [15:0] obs;
      raw_in[1] = 1'b1;
      push_ev(6, 2'b10, 2'b00);
      step(8);
      raw_in[0] = 1'b1;
      step(4);
      n_chk++;
      if (level !== 2'b10) $display("FAIL mid_pre level=%b required=%b", level, 2'b10);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      obs = {sys_rst_n, level, rise, fall, tick, uptime};
      n_chk++;
      if (obs !== 16'h0000) $display("FAIL mid_reset_async got=%h required=%h", obs, 16'h0000);
      else n_pass++;
      step(3);
      rst_n = 1'b1;
      push_ev(9, 2'b11, 2'b00);
      step(4);
      n_chk++;
      if (sys_rst_n !== 1'b0) $display("FAIL mid_release_early sys_rst_n=%b required=0", sys_rst_n);
      else n_pass++;
      step(1);
      n_chk++;
      if (sys_rst_n !== 1'b1) $display("FAIL mid_release sys_rst_n=%b required=1", sys_rst_n);
      else n_pass++;
      step(3);
      n_chk++;
      if (level !== 2'b00) $display("FAIL reacq_early level=%b required=%b", level, 2'b00);
      else n_pass++;
      step(1);
      n_chk++;
      if (level !== 2'b11) $display("FAIL reacq_level level=%b required=%b", level, 2'b11);
      else n_pass++;
      step(3);
   endtask

   task automatic test_simultaneous();
      raw_in = 2'b10;
      push_ev(6, 2'b00, 2'b01);
      step(8);
      n_chk++;
      if (level !== 2'b10) $display("FAIL simul_setup level=%b required=%b", level, 2'b10);
      else n_pass++;
      raw_in = 2'b01;
      push_ev(6, 2'b01, 2'b10);
      step(8);
      n_chk++;
      if (level !== 2'b01) $display("FAIL simul_level level=%b required=%b", level, 2'b01);
      else n_pass++;
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL pulses_outstanding got=%0d required=0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      rst_n  = 1'b0;
      raw_in = 2'b00;
      test_reset();
      test_tick_uptime();
      test_clean_press();
      test_glitch();
      test_mid_reset();
      test_simultaneous();
      step(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
